// File: rtl/mbox_pkg.sv
// Shared MBOX definitions: requester indices and the SBUS sequencer state encoding.
package mbox_pkg;

  localparam int NREQ      = 3;
  localparam int REQ_CHAN  = 0;
  localparam int REQ_EBOX  = 1;
  localparam int REQ_SWEEP = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_ACK,
    ST_XFER,
    ST_DONE
  } sbus_arb_st_t;

endpackage

// File: rtl/mbox_sbus_arb_if.sv
// Requester and SBUS handshake bundle; the arbiter takes the master side.
interface mbox_sbus_arb_if;
  import mbox_pkg::*;

  logic [NREQ-1:0] req;
  logic [NREQ-1:0] wr;
  logic [NREQ-1:0] quad;
  logic [NREQ-1:0] grant;
  logic [1:0]      sel;
  logic [NREQ-1:0] done;
  logic [NREQ-1:0] nxm;
  logic            mem_start;
  logic            mem_wr;
  logic            mem_quad;
  logic            mem_ack;
  logic            mem_dv;

  modport master (
    input  req, wr, quad, mem_ack, mem_dv,
    output grant, sel, done, nxm, mem_start, mem_wr, mem_quad
  );

  modport slave (
    output req, wr, quad, mem_ack, mem_dv,
    input  grant, sel, done, nxm, mem_start, mem_wr, mem_quad
  );

endinterface

// File: rtl/mbox_arb_pick.sv
// Combinational winner picker: fixed priority CHAN > EBOX > SWEEP, with a starvation
// override that lets SWEEP past EBOX (never past CHAN).
module mbox_arb_pick
  import mbox_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            starve_hit,
  output logic [NREQ-1:0] win_oh,
  output logic [1:0]      win_idx
);

  logic [NREQ-1:0] higher;
  logic [NREQ-1:0] fixed_oh;
  logic            force_sweep;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_prio
    if (gi == 0) begin : g_first
      assign higher[gi] = 1'b0;
    end else begin : g_rest
      assign higher[gi] = higher[gi-1] | req[gi-1];
    end
    assign fixed_oh[gi] = req[gi] & ~higher[gi];
  end

  // req[SWEEP] is included so a stale saturated count never grants an idle sweeper.
  assign force_sweep = starve_hit & req[REQ_SWEEP] & ~req[REQ_CHAN];

  always_comb begin
    win_oh = fixed_oh;
    if (force_sweep) begin
      win_oh            = '0;
      win_oh[REQ_SWEEP] = 1'b1;
    end
    win_idx = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) win_idx = 2'(i);
    end
  end

endmodule

// File: rtl/mbox_sbus_arb.sv
// SBUS cycle arbiter/sequencer: grants one requester, runs a 1- or 4-word cycle with an
// ack/data timeout, and reports done (plus nxm on timeout) back to the winner.
module mbox_sbus_arb
  import mbox_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 63
) (
  input  logic            clk,
  input  logic            CROBAR,
  mbox_sbus_arb_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  sbus_arb_st_t    state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [1:0]      sel_q, sel_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] nxm_q, nxm_d;
  logic            start_q, start_d;
  logic            wr_q, wr_d;
  logic            quad_q, quad_d;
  logic [1:0]      wcnt_q, wcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [SW-1:0]   starve_q, starve_d;

  logic            starve_hit;
  logic            grant_evt;
  logic            tmo_hit;
  logic [NREQ-1:0] win_oh;
  logic [1:0]      win_idx;

  assign starve_hit = (starve_q == SW'(STARVE_LIMIT));
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT));

  mbox_arb_pick u_pick (
    .req        (bus.req),
    .starve_hit (starve_hit),
    .win_oh     (win_oh),
    .win_idx    (win_idx)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    wr_d      = wr_q;
    quad_d    = quad_q;
    done_d    = '0;
    nxm_d     = '0;
    start_d   = 1'b0;
    wcnt_d    = wcnt_q;
    tmo_d     = tmo_q;
    starve_d  = starve_q;
    grant_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          grant_evt = 1'b1;
          state_d   = ST_START;
          grant_d   = win_oh;
          sel_d     = win_idx;
          wr_d      = |(bus.wr & win_oh);
          quad_d    = |(bus.quad & win_oh);
          start_d   = 1'b1;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_ACK;
        tmo_d   = '0;
      end
      ST_WAIT_ACK: begin
        // A data beat riding on the ack is word 1; a lone data beat is noise.
        if (bus.mem_ack) begin
          tmo_d = '0;
          if (bus.mem_dv && !quad_q) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else begin
            state_d = ST_XFER;
            wcnt_d  = bus.mem_dv ? 2'd1 : 2'd0;
          end
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          nxm_d   = grant_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_XFER: begin
        if (bus.mem_dv) begin
          tmo_d = '0;
          if (!quad_q || wcnt_q == 2'd3) begin
            state_d = ST_DONE;
            done_d  = grant_q;
          end else begin
            wcnt_d = wcnt_q + 2'd1;
          end
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          done_d  = grant_q;
          nxm_d   = grant_q;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = '0;
        sel_d   = 2'd0;
        wr_d    = 1'b0;
        quad_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!bus.req[REQ_SWEEP]) begin
      starve_d = '0;
    end else if (grant_evt) begin
      if (win_oh[REQ_SWEEP]) begin
        starve_d = '0;
      end else if (!starve_hit) begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge CROBAR) begin
    if (CROBAR) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      sel_q    <= 2'd0;
      done_q   <= '0;
      nxm_q    <= '0;
      start_q  <= 1'b0;
      wr_q     <= 1'b0;
      quad_q   <= 1'b0;
      wcnt_q   <= 2'd0;
      tmo_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      nxm_q    <= nxm_d;
      start_q  <= start_d;
      wr_q     <= wr_d;
      quad_q   <= quad_d;
      wcnt_q   <= wcnt_d;
      tmo_q    <= tmo_d;
      starve_q <= starve_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.done      = done_q;
  assign bus.nxm       = nxm_q;
  assign bus.mem_start = start_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_quad  = quad_q;

endmodule
